// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Multi-port register file with per-register busy (scoreboard)
//               bits, two writeback ports, a reserve port, optional
//               write-to-read forwarding and a post-reset clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  output logic                init_done
);

  localparam logic [AW-1:0] c_last = AW'(NREG - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;

  logic w_ready;
  logic w_wr0_act;
  logic w_wr1_act;
  logic w_wr1_store;
  logic w_rsv_set;

  assign w_ready   = (r_state == ST_READY);
  assign init_done = w_ready;

  // Writes to register 0 and all writes during the sweep are dropped here.
  assign w_wr0_act   = w_ready && wr0_en && (wr0_addr != '0);
  assign w_wr1_act   = w_ready && wr1_en && (wr1_addr != '0);
  // On a same-address collision the ALU port wins; the load data is lost.
  assign w_wr1_store = w_wr1_act && !(w_wr0_act && (wr0_addr == wr1_addr));

  // A register being written this cycle may be re-reserved immediately.
  assign rsv_ok = w_ready &&
                  ((rsv_addr == '0) ||
                   !r_busy[rsv_addr] ||
                   (w_wr0_act && (wr0_addr == rsv_addr)) ||
                   (w_wr1_act && (wr1_addr == rsv_addr)));

  assign w_rsv_set = rsv_en && rsv_ok && (rsv_addr != '0);

  // Controller state and sweep index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sweep walks every register once, then READY is held until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_INIT: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == c_last) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Register array: cleared by the sweep rather than by reset; wr0 last so it wins.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_wr1_store) begin
        r_mem[wr1_addr] <= wr1_data;
      end
      if (w_wr0_act) begin
        r_mem[wr0_addr] <= wr0_data;
      end
    end
  end

  // Busy bits: writeback clears, reservation sets afterwards so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else if (r_state == ST_INIT) begin
      r_busy[r_idx] <= 1'b0;
    end else begin
      if (w_wr1_act) begin
        r_busy[wr1_addr] <= 1'b0;
      end
      if (w_wr0_act) begin
        r_busy[wr0_addr] <= 1'b0;
      end
      if (w_rsv_set) begin
        r_busy[rsv_addr] <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional forwarding from active writes.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_hit0;
    logic          w_hit1;

    assign w_a    = rd_addr[i*AW +: AW];
    assign w_hit0 = (BYPASS != 0) && w_wr0_act && (wr0_addr == w_a);
    assign w_hit1 = (BYPASS != 0) && w_wr1_act && (wr1_addr == w_a);

    assign rd_data[i*XLEN +: XLEN] = (!w_ready || (w_a == '0)) ? '0       :
                                     w_hit0                    ? wr0_data :
                                     w_hit1                    ? wr1_data :
                                                                 r_mem[w_a];

    assign rd_busy[i] = w_ready && (w_a != '0) && r_busy[w_a] && !w_hit0 && !w_hit1;
  end

endmodule
`default_nettype wire
